// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Imported by the register-file top and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  // Low bit index of port 'port' in a packed bus of 'w'-bit fields.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write flags: decode sets, writeback clears, set wins on a tie.
// Only updates once the post-reset clear sweep has finished.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_set,
  input  logic [AW-1:0]    i_set_addr,
  input  logic             i_clr,
  input  logic [AW-1:0]    i_clr_addr,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Next busy vector; a new producer supersedes the one retiring this cycle.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_run) begin
      for (int r = 0; r < NREGS; r++) begin
        if (ZERO_REG && (r == 0)) begin
          w_busy_nxt[r] = 1'b0;
        end else if (i_set && (i_set_addr == AW'(r))) begin
          w_busy_nxt[r] = 1'b1;
        end else if (i_clr && (i_clr_addr == AW'(r))) begin
          w_busy_nxt[r] = 1'b0;
        end else begin
          w_busy_nxt[r] = r_busy[r];
        end
      end
    end else begin
      w_busy_nxt = r_busy;
    end
  end

  // Busy flag register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, write-to-read bypass,
// pending-write scoreboard and a sequential post-reset clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic                ready
);

  localparam bit LP_ZERO = (ZERO_REG != 0);

  rf_state_t        r_state;
  rf_state_t        w_state_nxt;
  logic [AW-1:0]    r_clr_idx;
  logic [AW-1:0]    w_clr_idx_nxt;
  logic             r_ready;
  logic             w_ready_nxt;
  logic             w_run;
  logic [NREGS-1:0] w_busy;
  logic [XLEN-1:0]  r_rf [NREGS];

  assign w_run = (r_state == RF_RUN);
  assign ready = r_ready;

  // Clear-sweep FSM state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Sweep advances one register per cycle and hands over to RUN after the last one.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_ready_nxt   = r_ready;
    case (r_state)
      RF_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + AW'(1);
        if (r_clr_idx == AW'(NREGS - 1)) begin
          w_state_nxt = RF_RUN;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = RF_CLEAR;
          w_ready_nxt = 1'b0;
        end
      end
      RF_RUN: begin
        w_state_nxt = RF_RUN;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt   = RF_CLEAR;
        w_clr_idx_nxt = '0;
        w_ready_nxt   = 1'b0;
      end
    endcase
  end

  // Storage array: no reset, zeroed by the sweep, written by writeback in RUN.
  always_ff @(posedge CLK) begin
    if (r_state == RF_CLEAR) begin
      r_rf[r_clr_idx] <= '0;
    end else if (wr_en && !(LP_ZERO && (wr_addr == '0))) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (LP_ZERO)
  ) u_scoreboard (
    .CLK        (CLK),
    .reset      (reset),
    .i_run      (w_run),
    .i_set      (sb_set),
    .i_set_addr (sb_addr),
    .i_clr      (wr_en),
    .i_clr_addr (wr_addr),
    .o_busy     (w_busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_pend;

    assign w_addr = rd_addr[port_lo(i, AW) +: AW];

    // Read mux: zero register first, then same-cycle writeback bypass, then the array.
    always_comb begin
      w_data = '0;
      w_pend = 1'b0;
      if (!w_run) begin
        w_data = '0;
        w_pend = 1'b0;
      end else if (LP_ZERO && (w_addr == '0)) begin
        w_data = '0;
        w_pend = 1'b0;
      end else if (wr_en && (wr_addr == w_addr)) begin
        w_data = wr_data;
        w_pend = 1'b0;
      end else begin
        w_data = r_rf[w_addr];
        w_pend = w_busy[w_addr];
      end
    end

    assign rd_data[port_lo(i, XLEN) +: XLEN] = w_data;
    assign rd_busy[i]                        = w_pend;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the core's decode/writeback path. Generalises width, depth and read-port count.
- Adds a hardwired zero register, write-to-read bypass, and a per-register scoreboard of pending writes.
- Clears the array with a sequential post-reset sweep, so no asynchronous array-wide clear is needed.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers (power of two, >= 2)
NRD, 2, number of independent read ports (1..4)
ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never marked busy
AW, $clog2(NREGS), address width (localparam, derived)

Ports:
CLK  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
rd_addr  input  NRD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  packed read data, combinational
rd_busy  output  NRD  per-port "pending write outstanding" flag, combinational
wr_en  input  1  writeback strobe
wr_addr  input  AW  writeback address
wr_data  input  XLEN  writeback data
sb_set  input  1  decode issues an instruction that will write sb_addr
sb_addr  input  AW  register to mark busy
ready  output  1  high once the clear sweep is finished

Behaviour:
- Interface: reset is asynchronous, active-high; clock is CLK.
- States: CLEAR and RUN.
- On reset assertion, asynchronously: state=CLEAR, clr_idx=0, busy[]=0, ready=0. Array contents are undefined until the sweep completes.
- CLEAR: on each CLK edge with reset low, rf[clr_idx]<=0 and clr_idx++. After the edge that writes clr_idx==NREGS-1, state=RUN and ready=1. The sweep takes exactly NREGS cycles after reset deassertion.
- During CLEAR: wr_en and sb_set are ignored; rd_data=0 and rd_busy=0 on all ports.
- Reset mid-sweep, or reset during RUN, restarts the sweep from index 0.
- RUN write: if wr_en and not (ZERO_REG and wr_addr==0), then rf[wr_addr]<=wr_data. The array shows the new value from the next cycle.
- Read, per port i, combinational:
  - If ZERO_REG and rd_addr_i==0, rd_data_i=0.
  - Else if wr_en and wr_addr==rd_addr_i, rd_data_i=wr_data (same-cycle bypass).
  - Else rd_data_i=rf[rd_addr_i].
- Scoreboard, per register r, on each edge in RUN:
  - sb_set with sb_addr==r sets busy[r].
  - wr_en with wr_addr==r clears busy[r].
  - Both on the same r in the same cycle: set wins, because a new producer supersedes the retiring one.
  - r==0 with ZERO_REG: busy[0] stays 0.
- rd_busy_i = busy[rd_addr_i] & ~(wr_en & wr_addr==rd_addr_i). The retiring write is bypassed in that cycle, so the read is not busy. Forced to 0 for register 0 when ZERO_REG.
- All read ports are independent. Any number of ports may address the same register.
- Width rules: addresses are exactly AW bits; there is no out-of-range case because NREGS is a power of two.

Decomposition:
- Shared package regfile_pkg:
  - XLEN_DEFAULT=32, NREGS_DEFAULT=32.
  - State enum rf_state_t {RF_CLEAR, RF_RUN}.
  - Helper function for packed-port slicing.
- One sub-module, regfile_scoreboard: busy-bit vector plus set/clear priority logic, NREGS and AW parameters, asynchronous reset.
- Array, clear FSM and bypass muxes stay in regfile_mp.

Test Plan:
- Clear sweep: pulse reset, then drop it. ready=0 for exactly 32 cycles and goes high on cycle 32. Every register then reads 0 and every rd_busy=0.
- Write/read with bypass: in RUN, wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr0=5. rd_data0=0xDEADBEEF in the same cycle, and it still reads 0xDEADBEEF next cycle with wr_en=0.
- Zero register: wr_en=1, wr_addr=0, wr_data=0x12345678; sb_set=1, sb_addr=0. Port reading address 0 returns 0, and rd_busy for it stays 0.
- Scoreboard: sb_set at x7 → rd_busy=1 on the next cycle. Writeback to x7 → rd_busy=0 in that same cycle, with data 0xA5A5A5A5. Simultaneous sb_set and wr_en on x9 → busy[9]=1 afterwards.
- Writes during CLEAR: wr_en to x3 with 0xFFFFFFFF issued in sweep cycle 10 → after ready, x3 reads 0.
- Reset mid-run: load x4=0x55, assert reset asynchronously between edges → ready drops immediately and busy clears. After a full 32-cycle sweep, x4 reads 0.
